// File: rtl/comp_unit_seq.sv
// comp_unit_seq: multi-cycle wide-operand comparator / set-on-condition unit.
// Compares A and B one CHUNK at a time from the most significant end and stops
// at the first differing chunk, then decodes the latched condition into z.
module comp_unit_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int OUT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       ctrl,
    input  logic             sgn,
    output logic             busy,
    output logic             done,
    output logic [OUT_W-1:0] z,
    output logic             grtr,
    output logic             eql
);

    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int SH_W  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(N - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [IDX_W-1:0] idx_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [2:0]       ctrl_q;
    logic             sgn_q;

    logic             accept;
    logic [SH_W-1:0]  shamt;
    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic             chunk_diff;
    logic             chunk_last;
    logic             decide;
    logic             dec_grtr;
    logic             dec_eql;

    // Condition decode from the final ordering flags; ctrl[1] is ignored for eq/ne.
    function automatic logic cond_eval(input logic [2:0] c, input logic g, input logic e);
        logic r;
        r = 1'b0;
        if (c[2]) begin
            r = c[0] ? !e : e;
        end else begin
            case (c[1:0])
                2'b00:   r = !g && !e;
                2'b01:   r = !g;
                2'b10:   r = g;
                default: r = g || e;
            endcase
        end
        return r;
    endfunction

    // Start is honoured only when no compare is running.
    assign accept = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // Select the current chunk; in signed mode flipping the sign bit of the top
    // chunk turns two's-complement ordering into plain unsigned ordering.
    always_comb begin
        shamt   = SH_W'(32'(idx_q) * 32'(CHUNK));
        chunk_a = a_q[shamt +: CHUNK];
        chunk_b = b_q[shamt +: CHUNK];
        if (sgn_q && (idx_q == IDX_TOP)) begin
            chunk_a[CHUNK-1] = ~chunk_a[CHUNK-1];
            chunk_b[CHUNK-1] = ~chunk_b[CHUNK-1];
        end
        chunk_diff = (chunk_a != chunk_b);
        chunk_last = (idx_q == '0);
        decide     = (state_q == S_RUN) && (chunk_diff || chunk_last);
        dec_grtr   = (chunk_a > chunk_b);
        dec_eql    = !chunk_diff;
    end

    // Next-state logic: RUN until a decision, DONE for one cycle, optional back-to-back.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (decide) state_d = S_DONE;
            S_DONE:  state_d = start ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Control state, chunk index and the registered result flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= IDX_TOP;
            ctrl_q  <= 3'b000;
            sgn_q   <= 1'b0;
            z       <= '0;
            grtr    <= 1'b0;
            eql     <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                idx_q  <= IDX_TOP;
                ctrl_q <= ctrl;
                sgn_q  <= sgn;
            end else if ((state_q == S_RUN) && !decide) begin
                idx_q <= idx_q - 1'b1;
            end
            if (decide) begin
                grtr <= dec_grtr;
                eql  <= dec_eql;
                z    <= {{(OUT_W-1){1'b0}}, cond_eval(ctrl_q, dec_grtr, dec_eql)};
            end
        end
    end

    // Operand capture; pure datapath, so no reset needed.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q <= a;
            b_q <= b;
        end
    end

    assign busy = (state_q == S_RUN);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_comp_unit_seq.sv
// Bench for comp_unit_seq: default 8-bit chunks plus a CHUNK=32 instance.
module tb_comp_unit_seq;

    typedef struct {
        logic [31:0] z;
        logic        grtr;
        logic        eql;
        int          lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_d = 1'b0;
    logic        sel32 = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic [2:0]  ctrl = '0;
    logic        sgn = 1'b0;

    logic        start8, start32;
    logic        busy8, done8, grtr8, eql8;
    logic        busy32, done32, grtr32, eql32;
    logic [31:0] z8, z32;
    logic        busy_s, done_s, grtr_s, eql_s;
    logic [31:0] z_s;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   e0 = 0;
    int   last_lat = 0;

    assign start8  = start_d & ~sel32;
    assign start32 = start_d & sel32;
    assign busy_s  = sel32 ? busy32 : busy8;
    assign done_s  = sel32 ? done32 : done8;
    assign grtr_s  = sel32 ? grtr32 : grtr8;
    assign eql_s   = sel32 ? eql32 : eql8;
    assign z_s     = sel32 ? z32 : z8;

    comp_unit_seq #(.WIDTH(32), .CHUNK(8), .OUT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start8), .a(a), .b(b), .ctrl(ctrl), .sgn(sgn),
        .busy(busy8), .done(done8), .z(z8), .grtr(grtr8), .eql(eql8)
    );

    comp_unit_seq #(.WIDTH(32), .CHUNK(32), .OUT_W(32)) dut32 (
        .clk(clk), .rst(rst), .start(start32), .a(a), .b(b), .ctrl(ctrl), .sgn(sgn),
        .busy(busy32), .done(done32), .z(z32), .grtr(grtr32), .eql(eql32)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: whole-word compare, condition table, and first-differing-chunk latency.
    function automatic exp_t model(input logic [31:0] ma, input logic [31:0] mb,
                                   input logic [2:0] mc, input logic ms, input int cw);
        exp_t r;
        logic lt, gt, eq, bitv, found;
        logic [31:0] x;
        int n;
        lt = ms ? ($signed(ma) < $signed(mb)) : (ma < mb);
        gt = ms ? ($signed(ma) > $signed(mb)) : (ma > mb);
        eq = (ma == mb);
        if (mc[2]) bitv = mc[0] ? !eq : eq;
        else begin
            case (mc[1:0])
                2'b00:   bitv = lt;
                2'b01:   bitv = lt || eq;
                2'b10:   bitv = gt;
                default: bitv = !lt;
            endcase
        end
        r.z = {31'b0, bitv};
        r.grtr = gt;
        r.eql = eq;
        n = 32 / cw;
        r.lat = n;
        found = 1'b0;
        for (int k = 1; k <= n; k++) begin
            x = (ma ^ mb) >> ((n - k) * cw);
            if (cw < 32) x = x & ((32'd1 << cw) - 32'd1);
            if (!found && x != 0) begin
                r.lat = k;
                found = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic launch(input logic [31:0] ta, input logic [31:0] tb_, input logic [2:0] tc,
                          input logic ts, input string name);
        @(negedge clk);
        a = ta; b = tb_; ctrl = tc; sgn = ts; start_d = 1'b1;
        sb.push_back(model(ta, tb_, tc, ts, sel32 ? 32 : 8));
        @(posedge clk); #1;
        e0 = cyc;
        start_d = 1'b0;
        checks++;
        if (busy_s !== 1'b1 || done_s !== 1'b0) begin
            errors++;
            $display("FAIL %s accept: busy=%b done=%b, want busy=1 done=0", name, busy_s, done_s);
        end
    endtask

    task automatic wait_done(input string name);
        exp_t e;
        logic got;
        got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done_s === 1'b1) begin
                got = 1'b1;
                if (busy_s !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy_with_done: busy=%b, want 0", name, busy_s);
                end
            end else if (busy_s !== 1'b1) begin
                errors++;
                $display("FAIL %s busy_drop: busy=%b done=%b before done", name, busy_s, done_s);
            end
        end
        last_lat = cyc - e0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL %s timeout: no done within 40 cycles", name);
            if (sb.size() > 0) void'(sb.pop_front());
        end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: done with no expected entry", name);
        end else begin
            e = sb.pop_front();
            if (z_s !== e.z || grtr_s !== e.grtr || eql_s !== e.eql || last_lat != e.lat) begin
                errors++;
                $display("FAIL %s result: z=%h grtr=%b eql=%b lat=%0d, want z=%h grtr=%b eql=%b lat=%0d",
                         name, z_s, grtr_s, eql_s, last_lat, e.z, e.grtr, e.eql, e.lat);
            end
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy8, done8, grtr8, eql8} !== 4'b0 || z8 !== 32'd0 ||
            {busy32, done32, grtr32, eql32} !== 4'b0 || z32 !== 32'd0) begin
            errors++;
            $display("FAIL reset_state: busy=%b done=%b z=%h grtr=%b eql=%b, want all 0",
                     busy8, done8, z8, grtr8, eql8);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_unsigned_lt();
        launch(32'h0000_0005, 32'h0000_0009, 3'b000, 1'b0, "ult");
        wait_done("ult");
        checks++;
        if (z_s !== 32'd1 || grtr_s !== 1'b0 || eql_s !== 1'b0 || last_lat != 4) begin
            errors++;
            $display("FAIL ult_const: z=%h grtr=%b eql=%b lat=%0d, want z=1 grtr=0 eql=0 lat=4",
                     z_s, grtr_s, eql_s, last_lat);
        end
    endtask

    task automatic test_signed();
        launch(32'hFFFF_FFFF, 32'h0000_0001, 3'b000, 1'b1, "slt_signed");
        wait_done("slt_signed");
        checks++;
        if (z_s !== 32'd1 || grtr_s !== 1'b0 || last_lat != 1) begin
            errors++;
            $display("FAIL slt_signed_const: z=%h grtr=%b lat=%0d, want z=1 grtr=0 lat=1", z_s, grtr_s, last_lat);
        end
        launch(32'hFFFF_FFFF, 32'h0000_0001, 3'b000, 1'b0, "slt_unsigned");
        wait_done("slt_unsigned");
        checks++;
        if (z_s !== 32'd0 || grtr_s !== 1'b1 || last_lat != 1) begin
            errors++;
            $display("FAIL slt_unsigned_const: z=%h grtr=%b lat=%0d, want z=0 grtr=1 lat=1", z_s, grtr_s, last_lat);
        end
    endtask

    task automatic test_equality();
        logic [2:0]  cs [4] = '{3'b100, 3'b101, 3'b011, 3'b010};
        logic [31:0] zs [4] = '{32'd1, 32'd0, 32'd1, 32'd0};
        for (int i = 0; i < 4; i++) begin
            launch(32'h1234_5678, 32'h1234_5678, cs[i], 1'b0, "eq");
            wait_done("eq");
            checks++;
            if (z_s !== zs[i] || eql_s !== 1'b1 || last_lat != 4) begin
                errors++;
                $display("FAIL eq_ctrl%b: z=%h eql=%b lat=%0d, want z=%h eql=1 lat=4",
                         cs[i], z_s, eql_s, last_lat, zs[i]);
            end
        end
        // ne with an otherwise equal pair but differing low chunk
        launch(32'h1234_5678, 32'h1234_5679, 3'b111, 1'b1, "ne");
        wait_done("ne");
    endtask

    task automatic test_start_while_busy();
        launch(32'h0000_0001, 32'h0000_0002, 3'b000, 1'b0, "busy_start");
        @(posedge clk); #1;
        a = 32'hFFFF_FFFF; start_d = 1'b1;
        @(posedge clk); #1;
        start_d = 1'b0;
        wait_done("busy_start");
        checks++;
        if (z_s !== 32'd1 || last_lat != 4) begin
            errors++;
            $display("FAIL busy_start_const: z=%h lat=%0d, want z=1 lat=4", z_s, last_lat);
        end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done_s !== 1'b0) begin
                errors++;
                $display("FAIL busy_start_extra_done: done=%b at cycle %0d, want 0", done_s, i);
            end
        end
    endtask

    task automatic test_reset_mid_run();
        launch(32'h0000_0005, 32'h0000_0003, 3'b010, 1'b0, "pre_rst");
        wait_done("pre_rst");
        launch(32'h0000_0002, 32'h0000_0001, 3'b010, 1'b0, "mid_rst");
        @(posedge clk); #1;
        #2 rst = 1'b1;
        #1;
        void'(sb.pop_back());
        checks++;
        if (busy_s !== 1'b0 || done_s !== 1'b0 || z_s !== 32'd0 || grtr_s !== 1'b0 || eql_s !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst_clear: busy=%b done=%b z=%h grtr=%b eql=%b, want all 0",
                     busy_s, done_s, z_s, grtr_s, eql_s);
        end
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            checks++;
            if (done_s !== 1'b0 || busy_s !== 1'b0) begin
                errors++;
                $display("FAIL mid_rst_quiet: done=%b busy=%b at cycle %0d, want 0 0", done_s, busy_s, i);
            end
        end
        launch(32'h0000_0002, 32'h0000_0001, 3'b010, 1'b0, "post_rst");
        wait_done("post_rst");
        checks++;
        if (z_s !== 32'd1 || grtr_s !== 1'b1) begin
            errors++;
            $display("FAIL post_rst_const: z=%h grtr=%b, want z=1 grtr=1", z_s, grtr_s);
        end
    endtask

    // launch right after wait_done asserts start during the DONE cycle
    task automatic test_back_to_back();
        launch(32'h0000_0005, 32'h0000_0009, 3'b000, 1'b0, "b2b_first");
        wait_done("b2b_first");
        launch(32'h8000_0000, 32'h7FFF_FFFF, 3'b010, 1'b1, "b2b_second");
        checks++;
        if (cyc - e0 != 0 || last_lat != 4) begin
            errors++;
            $display("FAIL b2b_first_lat: lat=%0d, want 4", last_lat);
        end
        wait_done("b2b_second");
        checks++;
        if (z_s !== 32'd0 || last_lat != 1) begin
            errors++;
            $display("FAIL b2b_second_const: z=%h lat=%0d, want z=0 lat=1", z_s, last_lat);
        end
    endtask

    task automatic test_chunk32();
        logic [31:0] as [5] = '{32'h0000_0005, 32'hFFFF_FFFF, 32'h1234_5678, 32'h8000_0000, 32'h0000_0001};
        logic [31:0] bs [5] = '{32'h0000_0009, 32'h0000_0001, 32'h1234_5678, 32'h7FFF_FFFF, 32'h0000_0002};
        logic [2:0]  cs [5] = '{3'b000, 3'b000, 3'b100, 3'b010, 3'b011};
        logic        ss [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        @(negedge clk);
        sel32 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            launch(as[i], bs[i], cs[i], ss[i], "c32");
            wait_done("c32");
            checks++;
            if (last_lat != 1) begin
                errors++;
                $display("FAIL c32_lat: case %0d lat=%0d, want 1", i, last_lat);
            end
        end
        @(negedge clk);
        sel32 = 1'b0;
    endtask

    initial begin
        test_reset();
        test_unsigned_lt();
        test_signed();
        test_equality();
        test_start_while_busy();
        test_reset_mid_run();
        test_back_to_back();
        test_chunk32();
        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/comp_unit_seq.md
# comp_unit_seq

Parametrised sequential comparator and set-on-condition unit. Compares two WIDTH-bit operands chunk by chunk from the most significant end, in signed or unsigned mode, and terminates early on the first differing chunk. It decodes the 3-bit comparison control into an OUT_W-bit 0/1 result. It sits beside the ALU datapath as the multi-cycle slt/sle/sgt/sge/seq/sne engine for wide operands, handshaken with start/busy/done.

## Interface
- WIDTH, 32, operand width; must be a multiple of CHUNK
- CHUNK, 8, bits compared per cycle; CHUNK == WIDTH gives a single RUN cycle
- OUT_W, 32, result width
- clk  input  1  clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- start  input  1  request; sampled only when idle or in DONE
- a  input  WIDTH  operand A, latched on accepted start
- b  input  WIDTH  operand B, latched on accepted start
- ctrl  input  3  condition: 000 lt, 001 le, 010 gt, 011 ge, 1x0 eq, 1x1 ne
- sgn  input  1  1 = two's-complement compare, 0 = unsigned; latched on accepted start
- busy  output  1  high while in RUN
- done  output  1  one-cycle pulse when the result is valid
- z  output  OUT_W  result: bit 0 = condition true, bits OUT_W-1:1 = 0; held until the next result
- grtr  output  1  registered A > B from the last completed compare
- eql  output  1  registered A == B from the last completed compare

## Operation
- States: IDLE, RUN, DONE. N = WIDTH/CHUNK chunks; chunk index idx counts from N-1 (MSB) down to 0.
- IDLE + start: latch a, b, ctrl, sgn; set idx = N-1; go to RUN.
- RUN, each cycle: compare chunk idx of A and B.
  - In signed mode, the MSB of both top chunks is inverted before the compare. This maps two's-complement order onto unsigned order.
  - Chunks differ: grtr <= (A chunk > B chunk), eql <= 0, z <= decode; go to DONE.
  - Chunks equal and idx == 0: grtr <= 0, eql <= 1, z <= decode; go to DONE.
  - Otherwise: idx <= idx-1; stay in RUN.
- Decode of the condition bit:
  - lt = !grtr & !eql; le = !grtr; gt = grtr; ge = grtr | eql.
  - eq = eql; ne = !eql.
  - ctrl[1] is a don't-care when ctrl[2] = 1.
- DONE: done = 1 for exactly one cycle. Next state is RUN if start is high (back-to-back; new operands latched), else IDLE.
- start in RUN is ignored; the latched operands are unaffected.
- Operand inputs may change freely after an accepted start.

## Timing
- Reset (asynchronous, any time): state IDLE, busy 0, done 0, z 0, grtr 0, eql 0, idx N-1.
  - Reset mid-RUN aborts the compare; no done is produced.
- start accepted at edge E0: busy = 1 from E0.
- Decision in the k-th chunk from the MSB (k = 1..N; k = N when fully equal) is registered at edge Ek.
  - z, grtr and eql update at Ek.
  - busy falls at Ek.
  - done is high for the cycle Ek..Ek+1.
- Latency start->done: k cycles, best 1, worst N (4 for the defaults).
- Minimum issue interval: k+1 cycles, because start is accepted in the DONE cycle.
- done and busy are never high together.
- z, grtr and eql change only at a decision edge or on reset.

## Test plan
- Unsigned lt: a=0x00000005, b=0x00000009, ctrl=000, sgn=0.
  - Expect busy for 4 cycles, done pulse at E4, z=0x00000001, grtr=0, eql=0.
- Signed vs unsigned: a=0xFFFFFFFF, b=0x00000001, ctrl=000.
  - sgn=1: done at E1, z=1, grtr=0.
  - Repeat with sgn=0: done at E1, z=0, grtr=1.
- Equality: a=b=0x12345678.
  - ctrl=100: done at E4, z=1, eql=1.
  - ctrl=101: z=0.
  - ctrl=011: z=1.
  - ctrl=010: z=0.
- Start while busy: accept a=0x00000001, b=0x00000002, ctrl=000. Pulse start at E2 with a=0xFFFFFFFF.
  - Expect a single done at E4, z=1; no second done.
- Reset mid-RUN: assert rst asynchronously between E1 and E2.
  - Expect busy, done, z, grtr and eql to go 0 immediately and no done afterwards.
  - A new start after rst deasserts completes normally.
- Back-to-back: hold start high through the DONE cycle with new operands a=0x80000000, b=0x7FFFFFFF, ctrl=010, sgn=1.
  - The second compare is accepted at the DONE edge and finishes 1 cycle later with z=0.
  - Rerun with CHUNK=32: every compare completes at E1.
